conv_window_gen: RTL

//  Streaming front end for conv_layer / dwcv_layer: accepts an image as a raster-order pixel stream and emits every valid KxK window.

---
 rtl/conv_window_gen_if.sv | 39 +++
 rtl/conv_window_gen.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/conv_window_gen_if.sv
`default_nettype none
// ============================================================================
// Module  : conv_window_gen_if
// Purpose : Pixel-in / window-out handshake bundle for conv_window_gen.
// Revision: 1.0
// ============================================================================
interface conv_window_gen_if #(
    parameter int INPUT_SIZE     = 32,
    parameter int INPUT_CHANNELS = 3,
    parameter int KERNEL_SIZE    = 3,
    parameter int PX_SIZE        = 8
);
    localparam int OUTPUT_SIZE = INPUT_SIZE - (KERNEL_SIZE - 1);
    localparam int POS_W       = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1;
    localparam int PIX_W       = INPUT_CHANNELS * PX_SIZE;
    localparam int WIN_W       = KERNEL_SIZE * KERNEL_SIZE * PIX_W;

    logic             in_valid;
    logic             in_ready;
    logic             in_sof;
    logic [PIX_W-1:0] in_px;
    logic             out_valid;
    logic             out_ready;
    logic [WIN_W-1:0] out_window;
    logic [POS_W-1:0] out_row;
    logic [POS_W-1:0] out_col;
    logic             out_last;

    modport master (
        output in_valid, in_sof, in_px, out_ready,
        input  in_ready, out_valid, out_window, out_row, out_col, out_last
    );

    modport slave (
        input  in_valid, in_sof, in_px, out_ready,
        output in_ready, out_valid, out_window, out_row, out_col, out_last
    );
endinterface
`default_nettype wire

// File: rtl/conv_window_gen.sv
`default_nettype none
// ============================================================================
// Module  : conv_window_gen
// Purpose : Raster-order pixel stream to KxK sliding-window generator.
// Revision: 1.0
// ============================================================================
module conv_window_gen #(
    parameter int INPUT_SIZE     = 32,
    parameter int INPUT_CHANNELS = 3,
    parameter int KERNEL_SIZE    = 3,
    parameter int PX_SIZE        = 8
) (
    input  wire               clk,
    input  wire               rst_n,
    conv_window_gen_if.slave  bus
);
    localparam int OUTPUT_SIZE = INPUT_SIZE - (KERNEL_SIZE - 1);
    localparam int POS_W       = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1;
    localparam int PIX_W       = INPUT_CHANNELS * PX_SIZE;
    localparam int WIN_W       = KERNEL_SIZE * KERNEL_SIZE * PIX_W;
    localparam int CNT_W       = $clog2(INPUT_SIZE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INPUT_SIZE - 1);
    localparam logic [CNT_W-1:0] CNT_K1   = CNT_W'(KERNEL_SIZE - 1);

    typedef enum logic [0:0] {
        FILL   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] row_q, row_d;
    logic [CNT_W-1:0] col_q, col_d;
    logic [CNT_W-1:0] pos_r, pos_c;

    logic [PIX_W-1:0] lb_q  [KERNEL_SIZE-1][INPUT_SIZE];
    logic [PIX_W-1:0] lb_d  [KERNEL_SIZE-1][INPUT_SIZE];
    logic [PIX_W-1:0] win_q [KERNEL_SIZE][KERNEL_SIZE];
    logic [PIX_W-1:0] win_d [KERNEL_SIZE][KERNEL_SIZE];

    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic [POS_W-1:0] out_row_q, out_row_d;
    logic [POS_W-1:0] out_col_q, out_col_d;
    logic [WIN_W-1:0] out_window_q, out_window_d;

    logic             in_rdy;
    logic             accept;
    logic             emit;

    // Single output register: a new pixel may enter only if its window can land.
    assign in_rdy = !out_valid_q || bus.out_ready;
    assign accept = bus.in_valid && in_rdy;

    always_comb begin
        // Start-of-frame relocates the incoming pixel to the frame origin.
        if (bus.in_sof) begin
            pos_r = '0;
            pos_c = '0;
        end else begin
            pos_r = row_q;
            pos_c = col_q;
        end
        emit = accept && (state_q == STREAM) && !bus.in_sof && (pos_c >= CNT_K1);
    end

    always_comb begin
        row_d   = row_q;
        col_d   = col_q;
        state_d = state_q;
        if (accept) begin
            if (pos_c == CNT_LAST) begin
                col_d = '0;
                row_d = (pos_r == CNT_LAST) ? '0 : pos_r + 1'b1;
            end else begin
                col_d = pos_c + 1'b1;
                row_d = pos_r;
            end
            if ((pos_r == CNT_LAST) && (pos_c == CNT_LAST)) begin
                state_d = FILL;
            end else if (bus.in_sof) begin
                state_d = FILL;
            end else if ((pos_r == CNT_K1) && (pos_c == '0)) begin
                state_d = STREAM;
            end
        end
    end

    // Line buffer 0 holds the oldest row; each accept cascades one column upward.
    always_comb begin
        lb_d  = lb_q;
        win_d = win_q;
        if (accept) begin
            for (int r = 0; r < KERNEL_SIZE; r++) begin
                for (int c = 0; c < KERNEL_SIZE - 1; c++) begin
                    win_d[r][c] = win_q[r][c+1];
                end
            end
            for (int r = 0; r < KERNEL_SIZE - 1; r++) begin
                win_d[r][KERNEL_SIZE-1] = lb_q[r][pos_c];
            end
            win_d[KERNEL_SIZE-1][KERNEL_SIZE-1] = bus.in_px;
            for (int r = 0; r < KERNEL_SIZE - 2; r++) begin
                lb_d[r][pos_c] = lb_q[r+1][pos_c];
            end
            lb_d[KERNEL_SIZE-2][pos_c] = bus.in_px;
        end
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        out_row_d    = out_row_q;
        out_col_d    = out_col_q;
        out_window_d = out_window_q;
        if (emit) begin
            out_valid_d = 1'b1;
            out_last_d  = (pos_r == CNT_LAST) && (pos_c == CNT_LAST);
            out_row_d   = POS_W'(pos_r - CNT_K1);
            out_col_d   = POS_W'(pos_c - CNT_K1);
            for (int r = 0; r < KERNEL_SIZE; r++) begin
                for (int c = 0; c < KERNEL_SIZE; c++) begin
                    out_window_d[(r*KERNEL_SIZE + c)*PIX_W +: PIX_W] = win_d[r][c];
                end
            end
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FILL;
            row_q        <= '0;
            col_q        <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_row_q    <= '0;
            out_col_q    <= '0;
            out_window_q <= '0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            out_row_q    <= out_row_d;
            out_col_q    <= out_col_d;
            out_window_q <= out_window_d;
        end
    end

    // Pixel storage carries no control meaning, so it is left unreset.
    always_ff @(posedge clk) begin
        lb_q  <= lb_d;
        win_q <= win_d;
    end

    assign bus.in_ready   = in_rdy;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_last   = out_last_q;
    assign bus.out_row    = out_row_q;
    assign bus.out_col    = out_col_q;
    assign bus.out_window = out_window_q;
endmodule
`default_nettype wire
